// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : voice_scheduler
// Purpose  : Polyphonic tone controller. One shared note-to-period lookup is
//            time-multiplexed across NUM_VOICES voices with a round-robin
//            scheduler; each voice then runs its own square-wave half-period
//            counter on a common prescaled tick, and the high voices are
//            counted into a small mix value.
// Ports    : clk       - system clock
//            rst       - synchronous active-high reset
//            key_on    - per-voice gate, 1 = sounding
//            note_in   - per-voice note index, voice v in [8v+7:8v]
//                        (1..88 valid, 0 = rest, >88 treated as rest)
//            lut_note  - note index presented to the period lookup
//            lut_hz    - half-period count returned by the lookup
//            voice_out - per-voice square wave
//            mix       - registered count of high voice_out bits
//            busy      - a lookup is pending or in flight
// Revision : 1.0 - initial release
// ============================================================================
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int TICK_DIV   = 132
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_VOICES-1:0]             key_on,
    input  logic [8*NUM_VOICES-1:0]           note_in,
    output logic [7:0]                        lut_note,
    input  logic [13:0]                       lut_hz,
    output logic [NUM_VOICES-1:0]             voice_out,
    output logic [$clog2(NUM_VOICES+1)-1:0]   mix,
    output logic                              busy
);

    localparam int c_SEL_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int c_MIX_W = $clog2(NUM_VOICES + 1);
    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [NUM_VOICES-1:0] r_pend;
    logic [NUM_VOICES-1:0] w_pend_nxt;
    logic [NUM_VOICES-1:0] r_key_q;
    logic [7:0]            w_note   [NUM_VOICES];
    logic [7:0]            r_stored [NUM_VOICES];
    logic [13:0]           r_period [NUM_VOICES];
    logic [c_SEL_W-1:0]    r_sel;
    logic [c_SEL_W-1:0]    r_rr;
    logic [c_SEL_W-1:0]    w_pick;
    logic [c_SEL_W-1:0]    w_idx;
    logic                  w_found;
    logic                  w_issue;
    logic                  w_tick;
    logic [c_PRE_W-1:0]    r_presc;
    logic [7:0]            r_lut_note;
    logic [c_MIX_W-1:0]    r_mix;
    logic [c_MIX_W-1:0]    w_pop;

    // Out-of-range notes become rests so the lookup never sees >88.
    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_clamp
        assign w_note[gv] = (note_in[8*gv +: 8] > 8'd88) ? 8'd0 : note_in[8*gv +: 8];
    end

    // First pending voice at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_idx = c_SEL_W'((int'(r_rr) + i) % NUM_VOICES);
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_issue = (r_state == c_ST_IDLE) && w_found;

    // A voice becomes pending on a rising gate or when its clamped note no
    // longer matches what was last looked up. The voice being issued this
    // cycle is cleared: the note stored for it is the note it has right now.
    always_comb begin
        w_pend_nxt = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_pend_nxt[v] = key_on[v] & (r_pend[v] | ~r_key_q[v] | (w_note[v] != r_stored[v]));
        end
        if (w_issue) begin
            w_pend_nxt[w_pick] = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_found) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:   w_state_nxt = c_ST_CAPTURE;
            c_ST_CAPTURE: w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // lut_note is registered on the edge entering ISSUE so the lookup's own
    // register has the result ready for sampling at the end of CAPTURE.
    // The gate history reloads from the live key levels during reset so a
    // key held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= '0;
            r_key_q    <= key_on;
            r_sel      <= '0;
            r_rr       <= '0;
            r_lut_note <= 8'd0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_stored[v] <= 8'd0;
                r_period[v] <= 14'd0;
            end
        end else begin
            r_pend  <= w_pend_nxt;
            r_key_q <= key_on;
            if (w_issue) begin
                r_sel              <= w_pick;
                r_lut_note         <= w_note[w_pick];
                r_stored[w_pick]   <= w_note[w_pick];
            end
            if (r_state == c_ST_CAPTURE) begin
                r_period[r_sel] <= lut_hz;
                r_rr            <= (r_sel == c_SEL_W'(NUM_VOICES - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

    // Common tick prescaler.
    assign w_tick = (r_presc == c_PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Per-voice half-period counters. The >= compare keeps a counter that is
    // already past a freshly shortened period from running on to wrap-around.
    for (genvar gv = 0; gv < NUM_VOICES; gv++) begin : g_voice
        logic [13:0] r_cnt;
        logic        r_tone;

        always_ff @(posedge clk) begin
            if (rst || !key_on[gv] || (r_period[gv] == 14'd0)) begin
                r_cnt  <= 14'd0;
                r_tone <= 1'b0;
            end else if (w_tick) begin
                if (r_cnt >= r_period[gv] - 14'd1) begin
                    r_cnt  <= 14'd0;
                    r_tone <= ~r_tone;
                end else begin
                    r_cnt <= r_cnt + 14'd1;
                end
            end
        end

        assign voice_out[gv] = r_tone;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_pop = w_pop + c_MIX_W'(voice_out[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_pop;
        end
    end

    assign lut_note = r_lut_note;
    assign mix      = r_mix;
    assign busy     = (|r_pend) || (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_voice_scheduler
// Purpose  : Self-checking bench for voice_scheduler. A behavioural model of
//            lookup scheduling and tone generation is stepped alongside the
//            DUT and every output is compared each cycle; directed checks pin
//            down the latency and interval figures.
// Revision : 1.0 - initial release
// ============================================================================
module tb_voice_scheduler;

    localparam int NV = 4;
    localparam int TD = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NV-1:0]   key_on;
    logic [8*NV-1:0] note_in;
    logic [7:0]      lut_note;
    logic [13:0]     lut_hz = 14'd0;
    logic [NV-1:0]   voice_out;
    logic [2:0]      mix;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_pend[NV], m_stored[NV], m_period[NV], m_keyq[NV], m_cnt[NV], m_out[NV];
    int m_phase, m_sel, m_rr, m_lut, m_presc, m_mix;

    voice_scheduler #(.NUM_VOICES(NV), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .key_on(key_on), .note_in(note_in),
        .lut_note(lut_note), .lut_hz(lut_hz), .voice_out(voice_out),
        .mix(mix), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in synthesizer lookup: fixed values for the documented notes,
    // short periods elsewhere so random runs toggle often.
    function automatic int lut_fn(input int n);
        case (n)
            0:       return 0;
            1:       return 6892;
            40:      return 723;
            49:      return 429;
            61:      return 213;
            73:      return 106;
            88:      return 44;
            default: return 20 + n;
        endcase
    endfunction

    always @(posedge clk) lut_hz <= 14'(lut_fn(int'(lut_note)));

    function automatic int clampn(input int n);
        return (n > 88) ? 0 : n;
    endfunction

    function automatic int note_of(input int v);
        return int'(note_in[8*v +: 8]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_pend[v] = 0; m_stored[v] = 0; m_period[v] = 0;
            m_cnt[v] = 0; m_out[v] = 0; m_keyq[v] = int'(key_on[v]);
        end
        m_phase = 0; m_sel = 0; m_rr = 0; m_lut = 0; m_presc = 0; m_mix = 0;
    endtask

    // Advance the model over one clock using the inputs now applied, clock
    // the DUT, then compare every output on the falling edge.
    task automatic step();
        int tick, any, pick, issue, pop, exp_busy;
        logic [NV-1:0] exp_vo;
        if (rst) begin
            model_reset();
        end else begin
            tick = (m_presc == TD - 1);
            m_presc = tick ? 0 : m_presc + 1;
            pop = 0;
            for (int v = 0; v < NV; v++) pop += m_out[v];
            m_mix = pop;
            for (int v = 0; v < NV; v++) begin
                if (!key_on[v] || m_period[v] == 0) begin
                    m_cnt[v] = 0; m_out[v] = 0;
                end else if (tick) begin
                    if (m_cnt[v] >= m_period[v] - 1) begin
                        m_cnt[v] = 0; m_out[v] = 1 - m_out[v];
                    end else begin
                        m_cnt[v]++;
                    end
                end
            end
            any = 0; pick = 0;
            for (int i = 0; i < NV; i++) begin
                if (!any && m_pend[(m_rr + i) % NV]) begin
                    any = 1; pick = (m_rr + i) % NV;
                end
            end
            issue = (m_phase == 0) && any;
            for (int v = 0; v < NV; v++) begin
                m_pend[v] = key_on[v] && (m_pend[v] || !m_keyq[v] ||
                            clampn(note_of(v)) != m_stored[v]);
            end
            if (issue) m_pend[pick] = 0;
            case (m_phase)
                0: if (issue) begin
                       m_lut = clampn(note_of(pick));
                       m_stored[pick] = m_lut;
                       m_sel = pick;
                       m_phase = 1;
                   end
                1: m_phase = 2;
                default: begin
                    m_period[m_sel] = lut_fn(m_lut);
                    m_rr = (m_sel + 1) % NV;
                    m_phase = 0;
                end
            endcase
            for (int v = 0; v < NV; v++) m_keyq[v] = int'(key_on[v]);
        end
        @(posedge clk);
        @(negedge clk);
        exp_busy = 0;
        for (int v = 0; v < NV; v++) begin
            exp_vo[v] = m_out[v][0];
            if (m_pend[v]) exp_busy = 1;
        end
        if (m_phase != 0) exp_busy = 1;
        chk("lut_note", 32'(lut_note), 32'(m_lut));
        chk("voice_out", 32'(voice_out), 32'(exp_vo));
        chk("mix", 32'(mix), 32'(m_mix));
        chk("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic set_note(input int v, input int n);
        note_in[8*v +: 8] = 8'(n);
    endtask

    // Steps until voice_out[idx] changes; n = steps taken, -1 if none.
    task automatic wait_change(input int idx, input int budget, output int n);
        logic start;
        start = voice_out[idx];
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (voice_out[idx] !== start) return;
        end
        n = -1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1; key_on = '0; note_in = '0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int bcnt, at49, n, seq[4];
        rst = 1'b1; key_on = '0; note_in = '0;
        repeat (3) step();
        chk("rst_lut_note", 32'(lut_note), 0);
        chk("rst_voice_out", 32'(voice_out), 0);
        chk("rst_mix", 32'(mix), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Single voice, note 49.
        set_note(0, 49); key_on[0] = 1'b1;
        bcnt = 0; at49 = -1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (busy === 1'b1) bcnt++;
            if (lut_note === 8'd49 && at49 < 0) at49 = c;
        end
        chk("t1_lut49_cycle", 32'(at49), 2);
        chk("t1_busy_len", 32'(bcnt), 3);
        wait_change(0, 3000, n);
        chk("t1_first_toggle_seen", 32'(n > 0), 1);
        wait_change(0, 3000, n);
        chk("t1_toggle_interval", 32'(n), 32'(429 * TD));

        // All four voices at once.
        reset_pulse();
        set_note(0, 1); set_note(1, 40); set_note(2, 61); set_note(3, 88);
        key_on = '1;
        bcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (busy === 1'b1) bcnt++;
            if (c == 2)  seq[0] = int'(lut_note);
            if (c == 5)  seq[1] = int'(lut_note);
            if (c == 8)  seq[2] = int'(lut_note);
            if (c == 11) seq[3] = int'(lut_note);
        end
        chk("t2_busy_len", 32'(bcnt), 12);
        chk("t2_issue_v0", 32'(seq[0]), 1);
        chk("t2_issue_v1", 32'(seq[1]), 40);
        chk("t2_issue_v2", 32'(seq[2]), 61);
        chk("t2_issue_v3", 32'(seq[3]), 88);
        wait_change(3, 500, n);
        wait_change(3, 500, n);
        chk("t2_v3_interval", 32'(n), 32'(44 * TD));

        // Voice 2 re-pitched during voice 3's ISSUE cycle.
        reset_pulse();
        set_note(2, 61); set_note(3, 20); key_on[2] = 1'b1; key_on[3] = 1'b1;
        repeat (5) step();
        set_note(2, 73);
        repeat (10) step();
        wait_change(2, 2000, n);
        chk("t3_v2_toggle_seen", 32'(n > 0), 1);
        wait_change(2, 2000, n);
        chk("t3_v2_interval", 32'(n), 32'(106 * TD));

        // Rest and out-of-range notes.
        reset_pulse();
        set_note(1, 0); set_note(3, 95); key_on[1] = 1'b1; key_on[3] = 1'b1;
        repeat (200) step();
        chk("t4_lut_rest", 32'(lut_note), 0);
        chk("t4_voices_silent", 32'(voice_out), 0);
        chk("t4_mix_zero", 32'(mix), 0);

        // Key release while high, then re-key.
        reset_pulse();
        set_note(1, 88); key_on[1] = 1'b1;
        wait_change(1, 500, n);
        chk("t5_v1_high", 32'(voice_out[1]), 1);
        key_on[1] = 1'b0;
        step();
        chk("t5_v1_cleared", 32'(voice_out[1]), 0);
        chk("t5_mix_lag", 32'(mix), 1);
        step();
        chk("t5_mix_drop", 32'(mix), 0);
        key_on[1] = 1'b1;
        bcnt = 0;
        repeat (6) begin step(); if (busy === 1'b1) bcnt++; end
        chk("t5_rekey_busy", 32'(bcnt), 3);

        // Reset landing on CAPTURE, key held through reset.
        reset_pulse();
        set_note(0, 49); key_on[0] = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t6_rst_lut", 32'(lut_note), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_vo", 32'(voice_out), 0);
        set_note(0, 0);
        step();
        rst = 1'b0;
        bcnt = 0;
        repeat (10) begin step(); if (busy === 1'b1) bcnt++; end
        chk("t6_held_no_retrigger", 32'(bcnt), 0);
        key_on[0] = 1'b0; step();
        set_note(0, 49); key_on[0] = 1'b1;
        bcnt = 0;
        repeat (6) begin step(); if (busy === 1'b1) bcnt++; end
        chk("t6_toggle_retrigger", 32'(bcnt), 3);

        // Randomised traffic.
        for (int c = 0; c < 6000; c++) begin
            if ($urandom_range(0, 15) == 0) key_on[$urandom_range(0, NV-1)] ^= 1'b1;
            if ($urandom_range(0, 11) == 0) set_note($urandom_range(0, NV-1), $urandom_range(0, 100));
            rst = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Polyphonic tone controller that shares one note-to-period lookup (synthesizer block, 1-cycle registered lookup, 14-bit half-period count) among NUM_VOICES voices.
- Round-robin schedules lookups on note/key changes and latches each voice's period.
- Runs one square-wave half-period counter per voice on a common prescaled tick.
- Sums active voices into a small mix value for the audio output stage.

Parameters:
- NUM_VOICES, 4, number of independent voices; 1..8.
- TICK_DIV, 132, clk cycles per counter tick; 50 MHz / 132 gives A4 (count 429) ≈ 441 Hz.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- key_on  in  NUM_VOICES  per-voice gate; 1 = sounding.
- note_in  in  8*NUM_VOICES  per-voice note index; voice v is bits [8v+7:8v]; 1..88 valid, 0 = rest.
- lut_note  out  8  note index driven to the synthesizer lookup.
- lut_hz  in  14  half-period count returned by the lookup, valid one clk after lut_note.
- voice_out  out  NUM_VOICES  per-voice square wave.
- mix  out  clog2(NUM_VOICES+1)  count of voice_out bits currently high.
- busy  out  1  high while any lookup is pending or in flight.

Behaviour:
- Reset values: lut_note=0, voice_out=0, mix=0, busy=0. All periods, pending flags, stored notes and counters clear; FSM goes to IDLE; prescaler clears; RR pointer = 0.
- Change detection (every cycle, per voice):
  - pending[v] is set when key_on[v] rises, or when key_on[v]=1 and note_in[v] != stored_note[v].
  - Out-of-range note_in (>88) is clamped to 0 before compare and issue. The lookup is never driven above 88.
- FSM:
  - IDLE: if any pending, pick the first pending voice at or after the RR pointer (wrapping), then go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): lut_note <= clamped note_in[sel]; stored_note[sel] <= same value; clear pending[sel]; go to CAPTURE.
  - CAPTURE (1 cycle): period[sel] <= lut_hz; RR pointer <= sel+1 mod NUM_VOICES; go to IDLE.
  - Lookup cost: 3 cycles per voice. Worst case after simultaneous changes on all voices: 3*NUM_VOICES cycles until all periods are valid.
- Same-cycle re-change: if a voice's note changes during or after ISSUE, it differs from stored_note, so pending re-sets and the voice is looked up again. No change is lost.
- busy = (any pending) or (FSM != IDLE).
- Prescaler: counts 0..TICK_DIV-1; tick is a 1-cycle pulse at the wrap.
- Per-voice tone counter:
  - If key_on[v]=0 or period[v]=0: counter=0 and voice_out[v]=0, held.
  - Else, on tick: if counter >= period[v]-1, then counter <= 0 and voice_out[v] toggles; otherwise counter increments.
  - A new period takes effect on the next tick. The counter is not reset on a period change, but the >= compare bounds the wrap when the period shrinks.
- key_on falling: voice_out[v] goes to 0 the next clk and the counter clears. period[v] is retained but stale. pending[v] clears; a pending lookup is dropped unless already in ISSUE/CAPTURE, which completes harmlessly.
- mix: registered popcount of voice_out, one clk behind voice_out.
- Reset mid-lookup: the in-flight capture is discarded and the FSM returns to IDLE.

Test Plan:
- Reset, then key_on[0]=1 with note_in[0]=49:
  - lut_note=49 on cycle 2 after the edge; period[0]=429 one cycle later.
  - voice_out[0] toggles every 429 ticks (56,628 clk with TICK_DIV=132).
  - busy high for exactly 3 cycles.
- All 4 voices key on in the same cycle with notes 1, 40, 61, 88:
  - Lookups issue in order v0, v1, v2, v3, each 3 cycles apart.
  - Periods latched: 6892, 723, 213, 44.
  - busy falls after 12 cycles.
- Voice 2 at note 61, then note_in changes to 73 on the ISSUE cycle of another voice:
  - Second lookup follows; period[2]=106.
  - The toggle interval shortens from 213 to 106 ticks with no stuck counter.
- note_in=0 or 95 with key_on=1:
  - lut_note driven 0, period=0.
  - voice_out stays 0 and mix excludes that voice.
- key_on[1] falls while voice 1 is high:
  - voice_out[1]=0 next clk, mix decrements the following clk.
  - Re-keying the same note triggers a fresh lookup.
- Assert rst during CAPTURE:
  - All outputs 0 next clk and FSM in IDLE.
  - After release, held key_on levels produce new rising-edge lookups only when key_on toggles; level-held keys do not re-trigger.
